// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem/IC sweep checker: FSM state encoding and
// default operand width and responder latency.
package skolem_chk_pkg;

  localparam int DEF_W   = 4;
  localparam int DEF_LAT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/skolem_vec_delay.sv
// LAT-stage register delay line that aligns issued vectors with the responder's
// answer; LAT=0 degenerates to a plain wire.
module skolem_vec_delay #(
  parameter int WIDTH = 9,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (LAT == 0) begin : g_wire
      wire unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/skolem_ic_sweep_checker.sv
// Exhaustive sweep checker comparing a unit's Skolem/IC bit against (s >= t).
// Optional SKOLEM_STOP_ON_ERR_EN: stop issuing vectors at the first mismatch.
module skolem_ic_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int LAT = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cand_i,
  output logic [2*W-1:0]   vec_o,
  output logic             vec_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [2*W:0]     err_cnt_o,
  output logic [2*W:0]     ic_cnt_o,
  output logic [2*W-1:0]   first_err_o
);

  localparam int VW = 2 * W;
  localparam int CW = 2 * W + 1;
  localparam logic [VW-1:0] LAST_VEC   = '1;
  localparam logic [2:0]    DRAIN_LOAD = 3'((LAT > 0) ? (LAT - 1) : 0);

  state_t          state;
  logic [2:0]      drain_cnt;
  logic [VW-1:0]   d_vec;
  logic            d_valid;
  logic            expected;
  logic            mismatch;
  logic            issue_stop;
  logic [CW-1:0]   err_next;

  skolem_vec_delay #(
    .WIDTH (VW + 1),
    .LAT   (LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({vec_valid_o, vec_o}),
    .q     ({d_valid, d_vec})
  );

  assign expected = (d_vec[W-1:0] >= d_vec[VW-1:W]);
  assign mismatch = d_valid && (cand_i != expected);
  assign err_next = err_cnt_o + CW'(mismatch);

`ifdef SKOLEM_STOP_ON_ERR_EN
  assign issue_stop = mismatch;
`else
  assign issue_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      vec_o       <= '0;
      vec_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      err_cnt_o   <= '0;
      ic_cnt_o    <= '0;
      first_err_o <= '0;
    end else begin
      done_o <= 1'b0;

      // Scoring runs off the delayed valid, independent of the issue state.
      if (d_valid) begin
        if (expected) ic_cnt_o <= ic_cnt_o + CW'(1);
        if (mismatch) begin
          err_cnt_o <= err_next;
          if (err_cnt_o == '0) first_err_o <= d_vec;
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= SWEEP;
            vec_o       <= '0;
            vec_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            err_cnt_o   <= '0;
            ic_cnt_o    <= '0;
            first_err_o <= '0;
          end
        end
        SWEEP: begin
          if ((vec_o == LAST_VEC) || issue_stop) begin
            vec_valid_o <= 1'b0;
            if (LAT == 0) begin
              state  <= FIN;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= (err_next == '0);
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            vec_o <= vec_o + VW'(1);
          end
        end
        DRAIN: begin
          // The last in-flight compare lands in the final DRAIN cycle.
          if (drain_cnt == 3'd0) begin
            state  <= FIN;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
